// File: rtl/hex_divider_pkg.sv
// Shared types and constants for the hex_divider switch/7-segment divider.
// Holds FSM state encoding, operand widths and the active-low segment table.
package hex_divider_pkg;

  localparam int N_DIVIDEND = 8;
  localparam int N_DIVISOR  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Active-low segments, bit0 = a ... bit6 = g, digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_divider_seg7_decode.sv
// Nibble to active-low 7-segment pattern, purely combinational.
module seg7_decode
  import hex_divider_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/hex_divider.sv
// Sequential restoring divider: SW[7:0] / SW[17:14], one quotient bit per clock,
// started by a KEY[1] press; results shown on HEX0..2, LEDR and LEDG.
module hex_divider #(
  parameter int N_DIVIDEND = hex_divider_pkg::N_DIVIDEND,
  parameter int N_DIVISOR  = hex_divider_pkg::N_DIVISOR
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [17:0] LEDR,
  output logic [7:0]  LEDG
);
  import hex_divider_pkg::*;

  localparam int CW = $clog2(N_DIVIDEND);

  logic                  sync1_r, sync2_r, sync3_r, start_p_r;
  state_t                state_r, state_nxt_s;
  logic [CW-1:0]         cnt_r, cnt_nxt_s;
  logic [N_DIVIDEND-1:0] q_work_r, q_work_nxt_s, quot_r, quot_nxt_s;
  logic [N_DIVISOR-1:0]  r_work_r, r_work_nxt_s, d_reg_r, d_reg_nxt_s, rem_r, rem_nxt_s;
  logic                  done_r, done_nxt_s, dz_r, dz_nxt_s, pend_r, pend_nxt_s, busy_r;
  logic [N_DIVISOR:0]    t_s, diff_s;
  logic [6:0]            hex0_s, hex1_s, hex2_s, hex0_r, hex1_r, hex2_r;
  logic                  unused_s;

  assign unused_s = ^{KEY[3:2], SW[13:8]};

  // Next-state, datapath and result-register update logic
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    q_work_nxt_s = q_work_r;
    r_work_nxt_s = r_work_r;
    d_reg_nxt_s  = d_reg_r;
    quot_nxt_s   = quot_r;
    rem_nxt_s    = rem_r;
    done_nxt_s   = done_r;
    dz_nxt_s     = dz_r;
    pend_nxt_s   = pend_r;
    t_s          = {r_work_r, q_work_r[N_DIVIDEND-1]};
    diff_s       = t_s - {1'b0, d_reg_r};
    case (state_r)
      IDLE, DONE: begin
        // A zero divisor latched on the previous edge completes without RUN cycles.
        if (pend_r) begin
          state_nxt_s = DONE;
          quot_nxt_s  = '1;
          rem_nxt_s   = '0;
          dz_nxt_s    = 1'b1;
          done_nxt_s  = 1'b1;
          pend_nxt_s  = 1'b0;
        end else if (start_p_r) begin
          q_work_nxt_s = SW[N_DIVIDEND-1:0];
          d_reg_nxt_s  = SW[17 -: N_DIVISOR];
          r_work_nxt_s = '0;
          done_nxt_s   = 1'b0;
          dz_nxt_s     = 1'b0;
          if (SW[17 -: N_DIVISOR] == '0) begin
            pend_nxt_s = 1'b1;
            cnt_nxt_s  = '0;
          end else begin
            state_nxt_s = RUN;
            cnt_nxt_s   = CW'(N_DIVIDEND - 1);
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (t_s >= {1'b0, d_reg_r}) begin
          r_work_nxt_s = diff_s[N_DIVISOR-1:0];
          q_work_nxt_s = {q_work_r[N_DIVIDEND-2:0], 1'b1};
        end else begin
          r_work_nxt_s = t_s[N_DIVISOR-1:0];
          q_work_nxt_s = {q_work_r[N_DIVIDEND-2:0], 1'b0};
        end
        if (cnt_r == '0) begin
          state_nxt_s = DONE;
          quot_nxt_s  = q_work_nxt_s;
          rem_nxt_s   = r_work_nxt_s;
          done_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Displays decode the next result so the registered segments track quot/rem exactly.
  seg7_decode u_seg_q_lo (.nibble(quot_nxt_s[3:0]), .seg(hex0_s));
  seg7_decode u_seg_q_hi (.nibble(quot_nxt_s[7:4]), .seg(hex1_s));
  seg7_decode u_seg_rem  (.nibble(rem_nxt_s[3:0]),  .seg(hex2_s));

  // State, synchronizer and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      sync3_r   <= 1'b1;
      start_p_r <= 1'b0;
      state_r   <= IDLE;
      cnt_r     <= '0;
      q_work_r  <= '0;
      r_work_r  <= '0;
      d_reg_r   <= '0;
      quot_r    <= '0;
      rem_r     <= '0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
      pend_r    <= 1'b0;
      busy_r    <= 1'b0;
      hex0_r    <= SEG_TABLE[0];
      hex1_r    <= SEG_TABLE[0];
      hex2_r    <= SEG_TABLE[0];
    end else begin
      sync1_r   <= KEY[1];
      sync2_r   <= sync1_r;
      sync3_r   <= sync2_r;
      start_p_r <= sync3_r & ~sync2_r;
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      q_work_r  <= q_work_nxt_s;
      r_work_r  <= r_work_nxt_s;
      d_reg_r   <= d_reg_nxt_s;
      quot_r    <= quot_nxt_s;
      rem_r     <= rem_nxt_s;
      done_r    <= done_nxt_s;
      dz_r      <= dz_nxt_s;
      pend_r    <= pend_nxt_s;
      busy_r    <= (state_nxt_s == RUN);
      hex0_r    <= hex0_s;
      hex1_r    <= hex1_s;
      hex2_r    <= hex2_s;
    end
  end

  assign HEX0 = hex0_r;
  assign HEX1 = hex1_r;
  assign HEX2 = hex2_r;
  assign LEDR = {{(18 - N_DIVIDEND - N_DIVISOR){1'b0}}, rem_r, quot_r};
  assign LEDG = {5'b00000, dz_r, done_r, busy_r};

endmodule

// File: tb/tb_hex_divider.sv
// Directed scoreboard bench for hex_divider: reference quotients pushed on start,
// popped and compared once the divider reports done.
module tb_hex_divider;

  logic        CLOCK_50;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [6:0]  HEX0, HEX1, HEX2;
  logic [17:0] LEDR;
  logic [7:0]  LEDG;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];

  hex_divider dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .LEDR(LEDR), .LEDG(LEDG)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;  4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'h0) begin
      e.q = 8'hFF; e.r = 4'h0; e.dz = 1'b1;
    end else begin
      e.q = a / {4'h0, b}; e.r = 4'(a % {4'h0, b}); e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hex0"}, HEX0, 7'b1000000);
    chk({tag, "_hex1"}, HEX1, 7'b1000000);
    chk({tag, "_hex2"}, HEX2, 7'b1000000);
    chk({tag, "_ledr"}, LEDR, 18'h0);
    chk({tag, "_ledg"}, LEDG, 8'h0);
  endtask

  // mode 0: key held for the whole division; mode 1: re-press and SW change during RUN
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, input int mode);
    exp_t e;
    int   n;
    int   bud;
    logic busy_seen;
    SW = {b, 6'h00, a};
    sb.push_back(model(a, b));
    @(negedge CLOCK_50);
    KEY[1] = 1'b0;
    if (b != 4'h0) begin
      bud = 0;
      while (!LEDG[0] && bud < 30) begin @(negedge CLOCK_50); bud++; end
      chk("busy_rise", LEDG[0], 1'b1);
      chk("done_clear_on_start", LEDG[1], 1'b0);
      n = 0;
      while (LEDG[0] && n < 40) begin
        n++;
        if (mode == 1 && n == 1) KEY[1] = 1'b1;
        if (mode == 1 && n == 3) begin KEY[1] = 1'b0; SW = {4'h3, 6'h00, 8'h0F}; end
        @(negedge CLOCK_50);
      end
      chk("busy_len", n, 8);
    end else begin
      bud = 0;
      busy_seen = 1'b0;
      while (LEDG[1] && bud < 30) begin
        busy_seen |= LEDG[0]; @(negedge CLOCK_50); bud++;
      end
      chk("dz_done_fall", LEDG[1], 1'b0);
      n = 0;
      while (!LEDG[1] && n < 30) begin
        busy_seen |= LEDG[0]; n++; @(negedge CLOCK_50);
      end
      chk("dz_latency", n, 1);
      chk("dz_no_busy", busy_seen, 1'b0);
    end
    e = sb.pop_front();
    chk("quot", LEDR[7:0], e.q);
    chk("rem", LEDR[11:8], e.r);
    chk("ledr_hi_zero", LEDR[17:12], 6'h0);
    chk("done", LEDG[1], 1'b1);
    chk("dz", LEDG[2], e.dz);
    chk("ledg_hi_zero", LEDG[7:3], 5'h0);
    chk("hex0", HEX0, seg(e.q[3:0]));
    chk("hex1", HEX1, seg(e.q[7:4]));
    chk("hex2", HEX2, seg(e.r));
    repeat (5) @(negedge CLOCK_50);
    chk("held_no_rerun", LEDG[1:0], 2'b10);
    KEY[1] = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  initial begin
    int bud;
    KEY = 4'b1110;
    SW  = 18'h0;
    repeat (3) @(negedge CLOCK_50);
    chk_reset_outputs("reset");
    KEY = 4'b1111;
    repeat (4) @(negedge CLOCK_50);
    chk_reset_outputs("idle_no_start");

    run_div(8'd200, 4'd7, 0);
    run_div(8'd255, 4'd1, 0);
    run_div(8'd13, 4'd15, 0);
    run_div(8'h42, 4'd0, 0);
    run_div(8'd100, 4'd9, 1);

    // reset during RUN, then a fresh division
    SW = {4'd3, 6'h00, 8'd50};
    @(negedge CLOCK_50);
    KEY[1] = 1'b0;
    bud = 0;
    while (!LEDG[0] && bud < 30) begin @(negedge CLOCK_50); bud++; end
    chk("rst_run_busy", LEDG[0], 1'b1);
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1110;
    @(negedge CLOCK_50);
    chk_reset_outputs("midrun_reset");
    KEY = 4'b1111;
    repeat (4) @(negedge CLOCK_50);
    chk_reset_outputs("after_reset_idle");

    run_div(8'd77, 4'd5, 0);
    run_div(8'd0, 4'd3, 0);
    run_div(8'd240, 4'd0, 0);
    run_div(8'd15, 4'd15, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_divider.md
# hex_divider

Sequential 8-bit by 4-bit unsigned restoring divider for the DE2 board. It is the inverse companion of the 4x4 switch multiplier: its operands use the same switch fields, and its quotient/remainder go to the same 7-segment and LED resources. The quotient is produced one bit per clock over 8 iterations, started by a pushbutton press.

## Interface
Parameters:
- N_DIVIDEND, 8, dividend/quotient width
- N_DIVISOR, 4, divisor/remainder width

Ports:
- CLOCK_50  input  1  system clock; all state on rising edge
- KEY  input  4  active-low pushbuttons. KEY[0] = reset, synchronous and active-low. KEY[1] = start, active-low. KEY[3:2] unused.
- SW  input  18  SW[7:0] dividend; SW[17:14] divisor; others unused
- HEX0  output  7  quotient low nibble, active-low segments, bit0 = a … bit6 = g
- HEX1  output  7  quotient high nibble
- HEX2  output  7  remainder
- LEDR  output  18  [7:0] quotient; [11:8] remainder; others 0
- LEDG  output  8  [0] busy; [1] done; [2] div-by-zero; others 0

## Operation
- **Start detection.** KEY[1] passes through a 2-flop synchronizer, followed by a falling-edge detector. This produces a one-cycle start_p pulse.
- **FSM states:**
  - IDLE: initial state after reset.
  - RUN: counter cnt runs 7 down to 0.
  - DONE: result held.
  - On start_p in IDLE or DONE:
    - Latch dividend into q_work and divisor into d_reg.
    - Clear r_work; clear done and dz.
    - Set cnt = 7 and go to RUN.
  - start_p in RUN is ignored.
  - SW changes after the latch have no effect.
- **RUN iteration:**
  - t = {r_work, q_work[7]} (5 bits).
  - If t >= d_reg: r_work = t - d_reg, shift 1 into q_work LSB.
  - Else: r_work = t[3:0], shift 0 into q_work LSB.
  - When cnt = 0, go to DONE and copy q_work/r_work into the result registers quot and rem.
  - Otherwise decrement cnt.
- **Divide by zero.**
  - Detected at latch time (divisor == 0).
  - The FSM goes directly to DONE on the next edge with quot = 8'hFF, rem = 4'h0, dz = 1.
  - No RUN cycles occur.
- **Result registers.** quot and rem change only on entry to DONE; displays and LEDR always show them. The previous result stays visible while a new division runs.
- **Reset** (KEY[0] low at a rising edge), including mid-RUN, takes effect on that edge:
  - state = IDLE, cnt = 0
  - quot = 0, rem = 0, busy = 0, done = 0, dz = 0
  - synchronizer flops = 1 (released level)
- **Reset values of outputs:**
  - HEX0/1/2 = 7'b1000000 (digit 0)
  - LEDR = 0, LEDG = 0

## Timing
- Edge E0: start_p is high and operands are latched. busy (LEDG[0]) is high starting from the state after E0.
- Normal division: 8 RUN edges, E1..E8. At E8 the state becomes DONE, quot/rem are updated, busy drops and done rises.
  - Latency from start_p to result = 8 cycles.
  - Latency from the KEY[1] falling edge = 11 cycles (2 sync + 1 edge detect).
- Divide by zero: the result is visible after E1; busy is never asserted.
- done stays high until the next accepted start or reset.
- Back-to-back: a start_p in DONE at edge E restarts immediately; done falls after E.
- No width overflow is possible:
  - quotient ≤ 8'hFF;
  - remainder < divisor ≤ 15;
  - t fits in 5 bits.

## Structure
- The package hex_divider_pkg holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - widths N_DIVIDEND and N_DIVISOR;
  - the 16-entry active-low segment constant table.
- Sub-module seg7_decode: 4-bit nibble in, 7-bit active-low segments out. It is purely combinational and instantiated 3 times. It replaces hand-written sum-of-products per display.
- The FSM, synchronizer and datapath stay in the top module.

## Test plan
- SW[7:0] = 200, SW[17:14] = 7, press KEY[1] → after 8 cycles quot = 0x1C, rem = 4. HEX1 = "1", HEX0 = "C", HEX2 = "4", LEDG[1] = 1.
- 255 / 1 → quot = 0xFF, rem = 0; 13 / 15 → quot = 0x00, rem = 0xD. In both cases busy is high for exactly 8 cycles.
- 0x42 / 0 → one cycle later quot = 0xFF, rem = 0, LEDG[2] = 1; busy never asserted.
- Second KEY[1] press and SW change during RUN → ignored; result is the first operands' quotient at cycle 8.
- KEY[0] low at cycle 4 of RUN → next edge: all outputs at reset values and state IDLE. A subsequent start computes correctly.
- Held KEY[1] (single falling edge) → exactly one division. Pressing again in DONE → done drops and a new result arrives 8 cycles later.
